serial_cmd_engine: RTL and testbench

- Parametrised successor to the UART debugger serial driver.
- Frames debugger commands from a byte-level UART (rx/tx byte cores) into cmd/addr/data transactions for the debug controller and replies with readback data.
- Adds configurable field widths, byte-granular assembly and echo, timeout in every wait state, error replies, and counted burst programming with overrun detection.

---
 rtl/serial_cmd_engine.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_serial_cmd_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmd_engine.sv
// serial_cmd_engine: frames debugger commands arriving as UART bytes into
// cmd/addr/data transactions for the debug controller, echoes each received
// field, and returns readback data (or an all-ones error word). A command
// whose low CMD_W bits equal PROG_CMD starts counted burst programming:
// a DATA_W count N followed by N data words, written to incrementing addresses.
//
// Optional feature macro: SERIAL_CHECKSUM_EN. When defined, the final
// programming reply is the DATA_W running sum of programmed words instead of N.
//
// Ports:
//   clk, reset (async, active low)
//   rx_data/rx_valid        received byte strobe
//   tx_data/tx_start        byte transmit strobe; tx_idle from transmitter
//   ctrlr_busy, d_rd, error controller status and readback
//   cmd/addr/d_in/out_valid command issue to controller
//   timeout_err/overrun_err one-cycle abort pulses
//   busy                    high whenever not idle
module serial_cmd_engine #(
    parameter int unsigned CLK_RATE = 50,
    parameter int unsigned TIMEOUT  = 200,
    parameter int unsigned CMD_W    = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter logic [7:0]  PROG_CMD = 8'hF,
    parameter logic [7:0]  WR_CMD   = 8'hC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_idle,
    input  logic              ctrlr_busy,
    input  logic [DATA_W-1:0] d_rd,
    input  logic              error,
    output logic [CMD_W-1:0]  cmd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] d_in,
    output logic              out_valid,
    output logic              timeout_err,
    output logic              overrun_err,
    output logic              busy
);

    localparam int unsigned TIMEOUT_COUNT = TIMEOUT * CLK_RATE * 1000;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_COUNT + 1);
    localparam int unsigned ADDR_B = ADDR_W / 8;
    localparam int unsigned DATA_B = DATA_W / 8;
    localparam int unsigned TX_W   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W  = $clog2(TX_W / 8 + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RX_ADDR, S_RX_DATA, S_CTRLR, S_PROG_CNT, S_PROG_DATA, S_PROG_WR, S_TX
    } state_e;

    state_e              state_q, state_d, ret_q, ret_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [TX_W-1:0]     rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
    logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d, tx_left_q, tx_left_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   d_in_q, d_in_d;
    logic                out_valid_q, out_valid_d;
    logic                timeout_err_q, timeout_err_d;
    logic                overrun_err_q, overrun_err_d;
    logic [DATA_W-1:0]   prog_n_q, prog_n_d, words_q, words_d, hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
`ifdef SERIAL_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
`endif

    logic [TX_W-1:0]     rx_sh_next;
    logic [CNT_W-1:0]    last_idx;
    logic                asm_en, field_done;
    logic [DATA_W-1:0]   rx_word, issue_word, prog_reply;
    logic [7:0]          cmd_byte;

    // The byte assembler runs in every receive state, including S_PROG_WR
    // so that a word can land in the holding register while a write drains.
    assign asm_en     = (state_q == S_RX_ADDR) || (state_q == S_RX_DATA) ||
                        (state_q == S_PROG_CNT) || (state_q == S_PROG_DATA) ||
                        (state_q == S_PROG_WR);
    assign last_idx   = (state_q == S_RX_ADDR) ? CNT_W'(ADDR_B - 1) : CNT_W'(DATA_B - 1);
    assign field_done = asm_en && rx_valid && (rx_cnt_q == last_idx);
    assign rx_sh_next = (rx_sh_q << 8) | TX_W'(rx_data);
    assign rx_word    = rx_sh_next[DATA_W-1:0];

`ifdef SERIAL_CHECKSUM_EN
    assign prog_reply = sum_q;
`else
    assign prog_reply = prog_n_q;
`endif

    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        timer_d       = timer_q;
        rx_sh_d       = rx_sh_q;
        rx_cnt_d      = rx_cnt_q;
        tx_sh_d       = tx_sh_q;
        tx_left_d     = tx_left_q;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        d_in_d        = d_in_q;
        out_valid_d   = 1'b0;
        timeout_err_d = 1'b0;
        overrun_err_d = 1'b0;
        prog_n_d      = prog_n_q;
        words_d       = words_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
`ifdef SERIAL_CHECKSUM_EN
        sum_d         = sum_q;
`endif
        cmd_byte                = '0;
        cmd_byte[CMD_W-1:0]     = rx_data[CMD_W-1:0];
        issue_word              = hold_full_q ? hold_q : rx_word;

        if (asm_en && rx_valid) begin
            if (field_done) begin
                rx_sh_d  = '0;
                rx_cnt_d = '0;
            end else begin
                rx_sh_d  = rx_sh_next;
                rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    rx_sh_d  = '0;
                    rx_cnt_d = '0;
                    if (rx_data[CMD_W-1:0] == PROG_CMD[CMD_W-1:0]) begin
                        cmd_d       = WR_CMD[CMD_W-1:0];
                        addr_d      = '0;
                        words_d     = '0;
                        hold_full_d = 1'b0;
`ifdef SERIAL_CHECKSUM_EN
                        sum_d       = '0;
`endif
                        state_d     = S_PROG_CNT;
                    end else begin
                        cmd_d                = rx_data[CMD_W-1:0];
                        tx_sh_d              = '0;
                        tx_sh_d[TX_W-1 -: 8] = cmd_byte;
                        tx_left_d            = CNT_W'(1);
                        ret_d                = S_RX_ADDR;
                        state_d              = S_TX;
                    end
                end
            end
            S_RX_ADDR: begin
                if (field_done) begin
                    addr_d                    = rx_sh_next[ADDR_W-1:0];
                    tx_sh_d                   = '0;
                    tx_sh_d[TX_W-1 -: ADDR_W] = rx_sh_next[ADDR_W-1:0];
                    tx_left_d                 = CNT_W'(ADDR_B);
                    ret_d                     = S_RX_DATA;
                    state_d                   = S_TX;
                end
            end
            S_RX_DATA: begin
                if (field_done) begin
                    d_in_d                    = rx_word;
                    tx_sh_d                   = '0;
                    tx_sh_d[TX_W-1 -: DATA_W] = rx_word;
                    tx_left_d                 = CNT_W'(DATA_B);
                    ret_d                     = S_CTRLR;
                    state_d                   = S_TX;
                end
            end
            S_CTRLR: begin
                // busy from the controller is not yet valid in the issue cycle
                if (!out_valid_q && !ctrlr_busy) begin
                    tx_sh_d                   = '0;
                    tx_sh_d[TX_W-1 -: DATA_W] = error ? {DATA_W{1'b1}} : d_rd;
                    tx_left_d                 = CNT_W'(DATA_B);
                    ret_d                     = S_IDLE;
                    state_d                   = S_TX;
                end
            end
            S_PROG_CNT: begin
                if (field_done) begin
                    if (rx_word == '0) begin
                        tx_sh_d   = '0;
                        tx_left_d = CNT_W'(DATA_B);
                        ret_d     = S_IDLE;
                        state_d   = S_TX;
                    end else begin
                        prog_n_d  = rx_word;
                        state_d   = S_PROG_DATA;
                    end
                end
            end
            S_PROG_DATA: begin
                if (hold_full_q || field_done) begin
                    d_in_d      = issue_word;
                    out_valid_d = 1'b1;
                    state_d     = S_PROG_WR;
`ifdef SERIAL_CHECKSUM_EN
                    sum_d       = sum_q + issue_word;
`endif
                    // a word finishing while the held one is consumed refills it
                    hold_full_d = hold_full_q && field_done;
                    if (hold_full_q && field_done) hold_d = rx_word;
                end
            end
            S_PROG_WR: begin
                if (field_done && hold_full_q) begin
                    overrun_err_d = 1'b1;
                    hold_full_d   = 1'b0;
                    state_d       = S_IDLE;
                end else begin
                    if (field_done) begin
                        hold_d      = rx_word;
                        hold_full_d = 1'b1;
                    end
                    if (!out_valid_q && !ctrlr_busy) begin
                        addr_d  = addr_q + ADDR_W'(DATA_B);
                        words_d = words_q + DATA_W'(1);
                        if (words_q + DATA_W'(1) == prog_n_q) begin
                            tx_sh_d                   = '0;
                            tx_sh_d[TX_W-1 -: DATA_W] = prog_reply;
                            tx_left_d                 = CNT_W'(DATA_B);
                            ret_d                     = S_IDLE;
                            state_d                   = S_TX;
                        end else begin
                            state_d = S_PROG_DATA;
                        end
                    end
                end
            end
            S_TX: begin
                if (!tx_start_q && tx_idle) begin
                    if (tx_left_q != '0) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = tx_sh_q[TX_W-1 -: 8];
                        tx_sh_d    = tx_sh_q << 8;
                        tx_left_d  = tx_left_q - CNT_W'(1);
                    end else begin
                        state_d = ret_q;
                        if (ret_q == S_CTRLR) out_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Inactivity timer; an arriving byte always beats expiry.
        if (state_q == S_IDLE || rx_valid || tx_start_q || state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q == TMR_W'(TIMEOUT_COUNT - 1)) begin
            timer_d       = '0;
            timeout_err_d = 1'b1;
            tx_start_d    = 1'b0;
            out_valid_d   = 1'b0;
            rx_sh_d       = '0;
            rx_cnt_d      = '0;
            hold_full_d   = 1'b0;
            state_d       = S_IDLE;
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end

        if (state_d == S_IDLE && state_q != S_IDLE) begin
            rx_sh_d  = '0;
            rx_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            ret_q         <= S_IDLE;
            timer_q       <= '0;
            rx_sh_q       <= '0;
            rx_cnt_q      <= '0;
            tx_sh_q       <= '0;
            tx_left_q     <= '0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            cmd_q         <= '0;
            addr_q        <= '0;
            d_in_q        <= '0;
            out_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
            prog_n_q      <= '0;
            words_q       <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
`ifdef SERIAL_CHECKSUM_EN
            sum_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            timer_q       <= timer_d;
            rx_sh_q       <= rx_sh_d;
            rx_cnt_q      <= rx_cnt_d;
            tx_sh_q       <= tx_sh_d;
            tx_left_q     <= tx_left_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            d_in_q        <= d_in_d;
            out_valid_q   <= out_valid_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
            prog_n_q      <= prog_n_d;
            words_q       <= words_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
`ifdef SERIAL_CHECKSUM_EN
            sum_q         <= sum_d;
`endif
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign cmd         = cmd_q;
    assign addr        = addr_q;
    assign d_in        = d_in_q;
    assign out_valid   = out_valid_q;
    assign timeout_err = timeout_err_q;
    assign overrun_err = overrun_err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_cmd_engine.sv
// Bench for serial_cmd_engine: directed test-plan cases plus randomized read
// and burst-programming transactions checked against a transaction-level model.
module tb_serial_cmd_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_idle = 1'b1;
    logic        ctrlr_busy;
    logic [31:0] d_rd;
    logic        error;
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic        out_valid;
    logic        timeout_err;
    logic        overrun_err;
    logic        busy;

    always #5 clk = ~clk;

    serial_cmd_engine #(
        .CLK_RATE(1), .TIMEOUT(1), .CMD_W(4), .ADDR_W(32), .DATA_W(32),
        .PROG_CMD(8'hF), .WR_CMD(8'hC)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_idle(tx_idle),
        .ctrlr_busy(ctrlr_busy), .d_rd(d_rd), .error(error), .cmd(cmd),
        .addr(addr), .d_in(d_in), .out_valid(out_valid), .timeout_err(timeout_err),
        .overrun_err(overrun_err), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Environment: transmitter (busy 4 cycles per byte) and controller
    // (busy for busy_len cycles after each issue, or held by ctrlr_hold).
    logic [7:0]  tx_log[$];
    logic [3:0]  ov_cmd[$];
    logic [31:0] ov_addr[$];
    logic [31:0] ov_din[$];
    int          tx_cnt = 0;
    int          cb_cnt = 0;
    int          busy_len = 0;
    logic        ctrlr_hold = 1'b0;
    int          ovr_seen = 0;
    logic [31:0] pw[4];

    assign ctrlr_busy = ctrlr_hold || (cb_cnt != 0);

    always @(posedge clk) begin
        if (tx_start) begin
            tx_log.push_back(tx_data);
            tx_cnt  <= 4;
            tx_idle <= 1'b0;
        end else if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) tx_idle <= 1'b1;
        end
        if (out_valid) begin
            ov_cmd.push_back(cmd);
            ov_addr.push_back(addr);
            ov_din.push_back(d_in);
            cb_cnt <= busy_len;
        end else if (cb_cnt != 0) begin
            cb_cnt <= cb_cnt - 1;
        end
        if (overrun_err) ovr_seen <= ovr_seen + 1;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: observed no finish, required finish within 60000 cycles");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        idle(gap);
    endtask

    task automatic clear_logs();
        tx_log.delete(); ov_cmd.delete(); ov_addr.delete(); ov_din.delete();
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] exp[$]);
        check({tag, "_txlen"}, tx_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < tx_log.size(); i++)
            check($sformatf("%s_tx%0d", tag, i), tx_log[i], exp[i]);
    endtask

    // Full read transaction; expected traffic derived from the command rules.
    task automatic run_read(input string tag, input logic [7:0] c, input logic [31:0] a,
                            input logic [31:0] dat, input logic [31:0] rd, input logic err,
                            input int blen, input logic junk);
        logic [7:0]  exp[$];
        logic [31:0] reply;
        clear_logs();
        d_rd = rd; error = err; busy_len = blen;
        send_byte(c, 0);
        if (junk) send_byte(8'hA5, 0);   // lands during the echo and is dropped
        idle(40);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1);
        idle(40);
        for (int i = 3; i >= 0; i--) send_byte(dat[8*i +: 8], 1);
        idle(90);
        reply = err ? 32'hFFFF_FFFF : rd;
        exp.push_back({4'h0, c[3:0]});
        for (int i = 3; i >= 0; i--) exp.push_back(a[8*i +: 8]);
        for (int i = 3; i >= 0; i--) exp.push_back(dat[8*i +: 8]);
        for (int i = 3; i >= 0; i--) exp.push_back(reply[8*i +: 8]);
        check({tag, "_nissue"}, ov_cmd.size(), 1);
        if (ov_cmd.size() == 1) begin
            check({tag, "_cmd"}, ov_cmd[0], c[3:0]);
            check({tag, "_addr"}, ov_addr[0], a);
            check({tag, "_din"}, ov_din[0], dat);
        end
        expect_tx(tag, exp);
        check({tag, "_busy"}, busy, 0);
        error = 1'b0;
    endtask

    // Burst programming of n words from pw[].
    task automatic run_prog(input string tag, input int n, input int blen);
        logic [7:0]  exp[$];
        logic [31:0] reply;
        logic [31:0] cnt;
        logic [31:0] sum;
        clear_logs();
        busy_len = blen;
        cnt = n;
        sum = 0;
        send_byte(8'h0F, 1);
        for (int i = 3; i >= 0; i--) send_byte(cnt[8*i +: 8], 1);
        for (int w = 0; w < n; w++) begin
            for (int i = 3; i >= 0; i--) send_byte(pw[w][8*i +: 8], 1);
            sum = sum + pw[w];
        end
        idle(80);
`ifdef SERIAL_CHECKSUM_EN
        reply = (n == 0) ? 32'h0 : sum;
`else
        reply = cnt;
`endif
        for (int i = 3; i >= 0; i--) exp.push_back(reply[8*i +: 8]);
        check({tag, "_nissue"}, ov_cmd.size(), n);
        for (int w = 0; w < n && w < ov_cmd.size(); w++) begin
            check($sformatf("%s_cmd%0d", tag, w), ov_cmd[w], 4'hC);
            check($sformatf("%s_addr%0d", tag, w), ov_addr[w], 32'(4 * w));
            check($sformatf("%s_din%0d", tag, w), ov_din[w], pw[w]);
        end
        expect_tx(tag, exp);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int n;
        int base;
        logic [31:0] ra, rdat, rrd;
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; d_rd = '0; error = 1'b0;
        idle(3);
        check("rst_ctl", {tx_start, out_valid, timeout_err, overrun_err, busy}, 0);
        check("rst_data", {tx_data, cmd, addr, d_in}, 0);
        reset = 1'b1;
        idle(3);

        run_read("read", 8'h03, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 1'b0, 5, 1'b0);
        run_read("err", 8'h03, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 1'b1, 5, 1'b0);

        pw[0] = 32'h1111_1111; pw[1] = 32'h2222_2222; pw[2] = 32'h3333_3333;
        run_prog("prog", 3, 2);
        run_prog("prog0", 0, 0);

        // Timeout after a partial address field.
        clear_logs();
        send_byte(8'h02, 0);
        idle(40);
        send_byte(8'h00, 1);
        send_byte(8'h00, 0);
        n = 0;
        while (n < 2000 && timeout_err !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        check("tmo_cycle", n, 1000);
        idle(1);
        check("tmo_busy", busy, 0);
        check("tmo_nissue", ov_cmd.size(), 0);
        check("tmo_txlen", tx_log.size(), 1);
        run_read("after_tmo", 8'h05, 32'h0000_0040, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, 1, 1'b0);

        // Overrun: controller never frees up while three words stream in.
        clear_logs();
        ctrlr_hold = 1'b1;
        send_byte(8'h0F, 1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1);
        send_byte(8'h03, 1);
        for (int b = 0; b < 11; b++) send_byte(8'h40 + 8'(b), 1);
        check("ovr_early", ovr_seen, 0);
        send_byte(8'h4B, 0);
        check("ovr_pulse", overrun_err, 1);
        idle(2);
        check("ovr_busy", busy, 0);
        check("ovr_nissue", ov_cmd.size(), 1);
        check("ovr_txlen", tx_log.size(), 0);
        ctrlr_hold = 1'b0;
        idle(10);

        // Reset during the address echo.
        clear_logs();
        send_byte(8'h01, 0);
        idle(40);
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1);
        n = 0;
        while (n < 200 && tx_log.size() < 3) begin
            @(posedge clk); #1;
            n++;
        end
        check("rstmid_reach", tx_log.size() >= 3, 1);
        #3 reset = 1'b0;
        #1;
        check("rstmid_ctl", {tx_start, out_valid, timeout_err, overrun_err, busy}, 0);
        check("rstmid_data", {tx_data, cmd, addr, d_in}, 0);
        base = tx_log.size();
        @(posedge clk); #1;
        reset = 1'b1;
        idle(60);
        check("rstmid_notx", tx_log.size(), base);
        run_read("after_rst", 8'h07, 32'hA000_0004, 32'h0BAD_CAFE, 32'h5555_AAAA, 1'b0, 0, 1'b0);

        // Randomized reads and bursts.
        for (int t = 0; t < 6; t++) begin
            ra = $urandom; rdat = $urandom; rrd = $urandom;
            run_read($sformatf("rnd_rd%0d", t),
                     8'($urandom_range(0, 14)) | 8'($urandom_range(0, 15) << 4),
                     ra, rdat, rrd, ($urandom_range(0, 3) == 0), $urandom_range(0, 6),
                     1'($urandom_range(0, 1)));
        end
        for (int t = 0; t < 4; t++) begin
            for (int w = 0; w < 4; w++) pw[w] = $urandom;
            run_prog($sformatf("rnd_pg%0d", t), $urandom_range(1, 4), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
